alu_out_serializer: RTL and testbench

ALU_OUT_SERIALIZER -- requirements
Module: alu_out_serializer

---
 rtl/alu_out_serializer_if.sv | 22 ++
 rtl/alu_out_serializer.sv | 157 +++++++++++++++
 tb/tb_alu_out_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_out_serializer_if.sv
// Bundles the frame request inputs and the serial/status outputs of the
// ALU result serializer; master drives requests, slave is the serializer.
interface alu_out_serializer_if;
    logic        start;
    logic        err;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  err_flags;
    logic        sout;
    logic        busy;
    logic        done;

    modport master (
        output start, err, c, flags, err_flags,
        input  sout, busy, done
    );

    modport slave (
        input  start, err, c, flags, err_flags,
        output sout, busy, done
    );
endinterface

// File: rtl/alu_out_serializer.sv
// Serializes an ALU result (4 data packets + CRC'd control packet) or a single
// error control packet onto an idle-high line, 11-bit packets, one bit per clk.
module alu_out_serializer #(
    parameter int IFG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_out_serializer_if.slave   ser_if
);

    typedef enum logic [1:0] {IDLE, DATA, CTL, GAP} state_t;

    localparam logic [3:0] GAP_LAST = (IFG > 0) ? 4'(IFG - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic [2:0]  err_flags_q, err_flags_d;
    logic [2:0]  crc_q, crc_d;

    logic [7:0]  c_bytes [4];
    logic [7:0]  data_byte;
    logic [7:0]  ctl_payload;
    logic [7:0]  payload;
    logic        sout_c;

    // Shift-register form of CRC-3 (x^3+x+1), message consumed MSB first.
    function automatic logic [2:0] crc3(input logic [36:0] msg);
        logic [2:0] r;
        logic       fb;
        r = 3'b111;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ msg[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign c_bytes[gi] = c_q[8*(3-gi) +: 8];
        end
    endgenerate

    assign data_byte   = c_bytes[byte_cnt_q];
    assign ctl_payload = err_q ? {1'b1, err_flags_q, err_flags_q, ^{1'b1, err_flags_q, err_flags_q}}
                               : {1'b0, flags_q, crc_q};
    assign payload     = (state_q == CTL) ? ctl_payload : data_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            c_q         <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            err_flags_q <= '0;
            crc_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            err_flags_q <= err_flags_d;
            crc_q       <= crc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        c_d         = c_q;
        flags_d     = flags_q;
        err_d       = err_q;
        err_flags_d = err_flags_q;
        crc_d       = crc_q;

        unique case (state_q)
            IDLE: begin
                if (ser_if.start) begin
                    c_d         = ser_if.c;
                    flags_d     = ser_if.flags;
                    err_d       = ser_if.err;
                    err_flags_d = ser_if.err_flags;
                    crc_d       = crc3({ser_if.c, 1'b1, ser_if.flags});
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    state_d     = ser_if.err ? CTL : DATA;
                end
            end
            DATA: begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_d  = '0;
                    // Wraps 3->0, which later tells GAP the control packet is next.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (IFG > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else if (byte_cnt_q == 2'd3) begin
                        state_d = CTL;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = (byte_cnt_q == 2'd0) ? CTL : DATA;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            CTL: begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sout_c = 1'b1;
        if (state_q == DATA || state_q == CTL) begin
            case (bit_cnt_q)
                4'd0:    sout_c = 1'b0;
                4'd1:    sout_c = (state_q == CTL);
                4'd10:   sout_c = 1'b1;
                default: sout_c = payload[3'(4'd9 - bit_cnt_q)];
            endcase
        end
    end

    assign ser_if.sout = sout_c;
    assign ser_if.busy = (state_q != IDLE);
    assign ser_if.done = (state_q == CTL) && (bit_cnt_q == 4'd10);

endmodule

// File: tb/tb_alu_out_serializer.sv
// Directed and randomized checks of alu_out_serializer framing, CRC, parity,
// handshake timing, inter-packet gaps and asynchronous reset.
module tb_alu_out_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_out_serializer_if if0 ();
    alu_out_serializer_if if2 ();

    alu_out_serializer #(.IFG(0)) dut0 (.clk(clk), .rst_n(rst_n), .ser_if(if0));
    alu_out_serializer #(.IFG(2)) dut2 (.clk(clk), .rst_n(rst_n), .ser_if(if2));

    int checks = 0;
    int errors = 0;

    logic [127:0] got_sout, got_busy, got_done;
    logic [127:0] exp_sout, exp_busy, exp_done;
    logic [10:0]  exp_pkt [0:4];
    int           exp_len;
    int           exp_npk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog timeout");
    end

    // Long-division CRC: remainder of (init*x^37 + msg*x^3) mod x^3+x+1.
    function automatic logic [2:0] model_crc(input logic [36:0] msg);
        logic [39:0] v;
        v = {msg, 3'b000};
        v[39:37] = v[39:37] ^ 3'b111;
        for (int i = 39; i >= 3; i--)
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction

    task automatic build_expected(input logic e, input logic [31:0] cv, input logic [3:0] fv,
                                  input logic [2:0] efv, input int ifg);
        int idx;
        logic [7:0] pl;
        if (e) begin
            pl = {1'b1, efv, efv, ^{1'b1, efv, efv}};
            exp_pkt[0] = {1'b0, 1'b1, pl, 1'b1};
            exp_npk = 1;
        end else begin
            for (int p = 0; p < 4; p++) begin
                pl = cv >> (8 * (3 - p));
                exp_pkt[p] = {1'b0, 1'b0, pl, 1'b1};
            end
            exp_pkt[4] = {1'b0, 1'b1, 1'b0, fv, model_crc({cv, 1'b1, fv}), 1'b1};
            exp_npk = 5;
        end
        exp_sout = '0; exp_busy = '0; exp_done = '0;
        idx = 0;
        for (int p = 0; p < exp_npk; p++) begin
            for (int i = 0; i < 11; i++) begin
                exp_sout[idx] = exp_pkt[p][10 - i];
                idx++;
            end
            if (p < exp_npk - 1)
                for (int g = 0; g < ifg; g++) begin
                    exp_sout[idx] = 1'b1;
                    idx++;
                end
        end
        exp_len = idx;
        exp_sout[idx] = 1'b1;
        for (int k = 0; k < idx; k++) exp_busy[k] = 1'b1;
        exp_done[idx - 1] = 1'b1;
    endtask

    task automatic drive(input bit sel, input logic st, input logic e, input logic [31:0] cv,
                         input logic [3:0] fv, input logic [2:0] efv);
        if (sel) begin
            if2.start = st; if2.err = e; if2.c = cv; if2.flags = fv; if2.err_flags = efv;
        end else begin
            if0.start = st; if0.err = e; if0.c = cv; if0.flags = fv; if0.err_flags = efv;
        end
    endtask

    // Accept on the next rising edge, then scramble inputs to prove capture.
    task automatic launch(input bit sel, input logic e, input logic [31:0] cv,
                          input logic [3:0] fv, input logic [2:0] efv);
        drive(sel, 1'b1, e, cv, fv, efv);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
    endtask

    // got_*[k] holds the value seen in cycle k+1 after acceptance.
    task automatic collect(input bit sel, input int n);
        got_sout = '0; got_busy = '0; got_done = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got_sout[k] = sel ? if2.sout : if0.sout;
            got_busy[k] = sel ? if2.busy : if0.busy;
            got_done[k] = sel ? if2.done : if0.done;
        end
    endtask

    function automatic logic [10:0] pkt_at(input int base);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) r[10 - i] = got_sout[base + i];
        return r;
    endfunction

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 4'h3, 3'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h1234_5678, 4'h3, 3'h0);
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.sout, if0.busy, if0.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_dut0 got sout/busy/done=%b required 100", {if0.sout, if0.busy, if0.done});
        end
        checks++;
        if ({if2.sout, if2.busy, if2.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_dut2 got sout/busy/done=%b required 100", {if2.sout, if2.busy, if2.done});
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 3'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 3'h0);
        rst_n = 1'b1;
        collect(1'b0, 3);
        checks++;
        if (got_busy !== 128'd0 || got_sout[2:0] !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%h sout=%b required busy=0 sout=111", got_busy, got_sout[2:0]);
        end
        $display("test_reset: reset state and release checked");
    endtask

    task automatic test_normal();
        logic [7:0] ctl;
        launch(1'b0, 1'b0, 32'h0, 4'b0010, 3'b000);
        collect(1'b0, 56);
        build_expected(1'b0, 32'h0, 4'b0010, 3'b000, 0);
        checks++;
        if (got_sout !== exp_sout) begin
            errors++;
            $display("FAIL normal_sout got %h required %h", got_sout, exp_sout);
        end
        for (int k = 0; k < 8; k++) ctl[7 - k] = got_sout[46 + k];
        checks++;
        if (ctl !== 8'b0001_0110) begin
            errors++;
            $display("FAIL normal_ctl_payload got %b required 00010110", ctl);
        end
        checks++;
        if ($countones(got_busy) != 55 || got_busy[54] !== 1'b1 || got_busy[55] !== 1'b0) begin
            errors++;
            $display("FAIL normal_busy got %h required 55 cycles from cycle 1", got_busy);
        end
        checks++;
        if (got_done !== (128'd1 << 54)) begin
            errors++;
            $display("FAIL normal_done got %h required pulse at cycle 55", got_done);
        end
        $display("test_normal: c=00000000 flags=0010 frame of 55 cycles");
    endtask

    task automatic test_error();
        launch(1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b100);
        collect(1'b0, 12);
        checks++;
        if (pkt_at(0) !== 11'b0_1_11001001_1 || got_sout[11] !== 1'b1) begin
            errors++;
            $display("FAIL error_packet got %b required 01110010011 then idle", pkt_at(0));
        end
        checks++;
        if (got_busy !== 128'h7FF || got_done !== (128'd1 << 10)) begin
            errors++;
            $display("FAIL error_timing got busy=%h done=%h required busy=7ff done=400", got_busy, got_done);
        end
        $display("test_error: err_flags=100 single control packet");
    endtask

    task automatic test_ifg();
        logic [7:0] gaps;
        launch(1'b1, 1'b0, 32'h1234_5678, 4'b1001, 3'b000);
        collect(1'b1, 64);
        build_expected(1'b0, 32'h1234_5678, 4'b1001, 3'b000, 2);
        checks++;
        if (got_sout !== exp_sout) begin
            errors++;
            $display("FAIL ifg_sout got %h required %h", got_sout, exp_sout);
        end
        for (int p = 0; p < 4; p++) begin
            gaps[2*p]     = got_sout[p*13 + 11];
            gaps[2*p + 1] = got_sout[p*13 + 12];
        end
        checks++;
        if (gaps !== 8'hFF || got_sout[52] !== 1'b0) begin
            errors++;
            $display("FAIL ifg_gaps got %b ctl_start=%b required 11111111 ctl_start=0", gaps, got_sout[52]);
        end
        checks++;
        if ($countones(got_busy) != 63 || got_done !== (128'd1 << 62)) begin
            errors++;
            $display("FAIL ifg_timing got busy_cycles=%0d done=%h required 63 and pulse at cycle 63",
                     $countones(got_busy), got_done);
        end
        $display("test_ifg: IFG=2 frame of 63 cycles");
    endtask

    task automatic test_back_to_back();
        logic [127:0] a_sout, a_busy, a_done;
        build_expected(1'b0, 32'hA5C3_0F96, 4'b0101, 3'b000, 0);
        a_sout = exp_sout; a_busy = exp_busy; a_done = exp_done;
        build_expected(1'b1, 32'h0, 4'h0, 3'b011, 0);
        exp_sout = a_sout | (exp_sout << 56);
        exp_busy = a_busy | (exp_busy << 56);
        exp_done = a_done | (exp_done << 56);
        launch(1'b0, 1'b0, 32'hA5C3_0F96, 4'b0101, 3'b000);
        got_sout = '0; got_busy = '0; got_done = '0;
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            got_sout[k - 1] = if0.sout;
            got_busy[k - 1] = if0.busy;
            got_done[k - 1] = if0.done;
            if (k == 5 || k == 55) drive(1'b0, 1'b1, 1'b1, 32'h0, 4'h0, 3'b111);
            else if (k == 56)      drive(1'b0, 1'b1, 1'b1, 32'h0, 4'h0, 3'b011);
            else                   drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 3'b000);
        end
        checks++;
        if (got_sout !== exp_sout) begin
            errors++;
            $display("FAIL b2b_sout got %h required %h", got_sout, exp_sout);
        end
        checks++;
        if (pkt_at(56) !== 11'b0_1_10110111_1) begin
            errors++;
            $display("FAIL b2b_second_packet got %b required 01101101111", pkt_at(56));
        end
        checks++;
        if (got_busy !== exp_busy || got_done !== exp_done) begin
            errors++;
            $display("FAIL b2b_timing got busy=%h done=%h required busy=%h done=%h",
                     got_busy, got_done, exp_busy, exp_done);
        end
        $display("test_back_to_back: starts at 5/55 ignored, start at 56 begins frame at 57");
    endtask

    task automatic test_reset_mid_frame();
        logic seen_done;
        launch(1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1100, 3'b000);
        collect(1'b0, 19);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if0.sout, if0.busy, if0.done} !== 3'b100) begin
            errors++;
            $display("FAIL async_reset got sout/busy/done=%b required 100", {if0.sout, if0.busy, if0.done});
        end
        seen_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_done = seen_done | if0.done | if0.busy;
        end
        rst_n = 1'b1;
        collect(1'b0, 3);
        checks++;
        if (seen_done !== 1'b0 || got_busy !== 128'd0 || got_done !== 128'd0) begin
            errors++;
            $display("FAIL reset_abort got activity=%b busy=%h done=%h required all 0", seen_done, got_busy, got_done);
        end
        launch(1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1100, 3'b000);
        collect(1'b0, 56);
        build_expected(1'b0, 32'hDEAD_BEEF, 4'b1100, 3'b000, 0);
        checks++;
        if (got_sout !== exp_sout || got_busy !== exp_busy || got_done !== exp_done) begin
            errors++;
            $display("FAIL reset_restart got sout=%h busy=%h done=%h required sout=%h busy=%h done=%h",
                     got_sout, got_busy, got_done, exp_sout, exp_busy, exp_done);
        end
        $display("test_reset_mid_frame: abort at cycle 20, complete frame afterwards");
    endtask

    task automatic test_random();
        logic        e;
        logic [31:0] cv;
        logic [3:0]  fv;
        logic [2:0]  efv;
        int          bad;
        for (int n = 0; n < 1000; n++) begin
            e   = ($urandom_range(0, 3) == 0);
            cv  = $urandom;
            fv  = 4'($urandom_range(0, 15));
            efv = 3'($urandom_range(0, 7));
            build_expected(e, cv, fv, efv, 0);
            launch(1'b0, e, cv, fv, efv);
            collect(1'b0, exp_len + 1);
            bad = 0;
            for (int p = 0; p < exp_npk; p++) begin
                checks++;
                if (pkt_at(p * 11) !== exp_pkt[p]) begin
                    errors++; bad++;
                    $display("FAIL rand_pkt frame %0d pkt %0d got %b required %b", n, p, pkt_at(p * 11), exp_pkt[p]);
                end
            end
            checks++;
            if (got_busy !== exp_busy || got_done !== exp_done || got_sout[exp_len] !== 1'b1) begin
                errors++; bad++;
                $display("FAIL rand_timing frame %0d got busy=%h done=%h required busy=%h done=%h",
                         n, got_busy, got_done, exp_busy, exp_done);
            end
            $display("frame %0d err=%0b c=%h flags=%b err_flags=%b packets=%0d bad=%0d",
                     n, e, cv, fv, efv, exp_npk, bad);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 3'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 3'h0);
        test_reset();
        test_normal();
        test_error();
        test_ifg();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
